// File: rtl/spcm_reader_pkg.sv
// Shared constants and FSM encoding for the serial PCM read core.
package spcm_reader_pkg;

    localparam logic [7:0] SPCM_OP_READ      = 8'h03;
    localparam logic [7:0] SPCM_OP_FAST_READ = 8'h0B;

    // Width of the bit and close counters; phase lengths must fit below 2**16.
    localparam int SPCM_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_CLOSE
    } spcm_state_t;

endpackage

// File: rtl/spcm_reader_shifter.sv
// SCK divider, per-phase bit counter and mosi/miso shift registers.
module spcm_shifter
    import spcm_reader_pkg::*;
#(
    parameter int TX_W    = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  run,
    input  logic [SPCM_CNT_W-1:0] nxt_bits,
    input  logic [TX_W-1:0]       tx_data,
    input  logic                  miso,
    output logic                  sck,
    output logic                  mosi,
    output logic                  phase_done,
    output logic [31:0]           rx_word
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [SPCM_CNT_W-1:0] bit_cnt;
    logic [TX_W-1:0]       tx_sr;
    logic                  tick;

    assign tick       = run && (div_cnt == DIV_MAX);
    assign phase_done = tick && sck && (bit_cnt == '0);
    assign mosi       = tx_sr[TX_W-1];

    // Zeros shift into tx_sr, so mosi is 0 through dummy/data and while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_word <= '0;
        end else if (start) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            bit_cnt <= nxt_bits;
            tx_sr   <= tx_data;
        end else if (run) begin
            if (tick) begin
                div_cnt <= '0;
                sck     <= ~sck;
                if (!sck) begin
                    rx_word <= {rx_word[30:0], miso};
                end else begin
                    tx_sr   <= {tx_sr[TX_W-2:0], 1'b0};
                    bit_cnt <= (bit_cnt == '0) ? nxt_bits : bit_cnt - SPCM_CNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spcm_reader.sv
// Serial PCM word reader: command/address/dummy/data framing with burst continuation.
module spcm_reader
    import spcm_reader_pkg::*;
#(
    parameter int ADDR_BITS      = 24,
    parameter int CLK_DIV        = 2,
    parameter int DUMMY_BITS     = 8,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic [ADDR_BITS-3:0] addr,
    input  logic                 burst,
    input  logic                 fast,
    output logic [31:0]          dout,
    output logic                 busy,
    output logic                 ack,
    output logic                 spcm_cs_n,
    output logic                 spcm_sck,
    output logic                 spcm_mosi,
    input  logic                 spcm_miso
);

    localparam int TX_W = 8 + ADDR_BITS;
    localparam bit USE_DUMMY = (DUMMY_BITS > 0);
    // CLOSE covers the rest of the SCK low half plus the cs_n-high hold.
    localparam logic [SPCM_CNT_W-1:0] CLOSE_LEN = SPCM_CNT_W'(CLK_DIV + CS_HIGH_CYCLES - 2);
    localparam logic [SPCM_CNT_W-1:0] CS_HI     = SPCM_CNT_W'(CS_HIGH_CYCLES);

    spcm_state_t           state, state_nxt;
    logic [SPCM_CNT_W-1:0] close_cnt, close_nxt;
    logic [SPCM_CNT_W-1:0] nxt_bits;
    logic [TX_W-1:0]       tx_data;
    logic [31:0]           rx_word;
    logic                  fast_q;
    logic                  start, run, phase_done, closing, cs_n_nxt;

    assign tx_data = {(fast ? SPCM_OP_FAST_READ : SPCM_OP_READ), addr, 2'b00};
    assign busy    = (state != S_IDLE);
    assign closing = (state == S_DATA) && ack && !burst;
    assign run     = (state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) && !closing;

    spcm_shifter #(
        .TX_W    (TX_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .run        (run),
        .nxt_bits   (nxt_bits),
        .tx_data    (tx_data),
        .miso       (spcm_miso),
        .sck        (spcm_sck),
        .mosi       (spcm_mosi),
        .phase_done (phase_done),
        .rx_word    (rx_word)
    );

    // nxt_bits is the length-1 of the phase that follows the current one.
    always_comb begin
        state_nxt = state;
        close_nxt = close_cnt;
        start     = 1'b0;
        nxt_bits  = SPCM_CNT_W'(31);
        case (state)
            S_IDLE: begin
                nxt_bits = SPCM_CNT_W'(7);
                if (cs) begin
                    start     = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                nxt_bits = SPCM_CNT_W'(ADDR_BITS - 1);
                if (phase_done) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (fast_q && USE_DUMMY) begin
                    nxt_bits = SPCM_CNT_W'(DUMMY_BITS - 1);
                    if (phase_done) state_nxt = S_DUMMY;
                end else if (phase_done) begin
                    state_nxt = S_DATA;
                end
            end
            S_DUMMY: begin
                if (phase_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (closing) begin
                    state_nxt = S_CLOSE;
                    close_nxt = CLOSE_LEN;
                end
            end
            S_CLOSE: begin
                if (close_cnt == '0) state_nxt = S_IDLE;
                else                 close_nxt = close_cnt - SPCM_CNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
        cs_n_nxt = !(state_nxt inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) &&
                   !((state_nxt == S_CLOSE) && (close_nxt >= CS_HI));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            close_cnt <= '0;
            fast_q    <= 1'b0;
            spcm_cs_n <= 1'b1;
            ack       <= 1'b0;
            dout      <= '0;
        end else begin
            state     <= state_nxt;
            close_cnt <= close_nxt;
            spcm_cs_n <= cs_n_nxt;
            ack       <= (state == S_DATA) && phase_done;
            if (start) fast_q <= fast;
            if ((state == S_DATA) && phase_done) dout <= rx_word;
        end
    end

endmodule

// File: tb/tb_spcm_reader.sv
// Directed bench for spcm_reader with a behavioural mode-0 SPI flash model.
module tb_spcm_reader;

    logic clk, rst;
    logic cs, burst, fast;
    logic [21:0] addr;
    logic [31:0] dout;
    logic busy, ack, spcm_cs_n, spcm_sck, spcm_mosi;

    logic cs2;
    logic [29:0] addr2;
    logic [31:0] dout2;
    logic busy2, ack2, cs2_n, sck2, mosi2;

    int n_cmp = 0, n_err = 0;

    // device model for the default-parameter instance
    logic [127:0] m_tx = '0, m_tx_last = '0;
    int m_bits = 0, m_last = 0, m_hdr_bits = 32, mj = 0;
    logic [6:0] mjb = '0;
    logic [31:0] m_words [4];
    logic m_miso = 1'b0;

    always @(posedge spcm_sck or posedge spcm_cs_n) begin
        if (spcm_cs_n) begin
            m_last = m_bits; m_tx_last = m_tx; m_bits = 0; m_tx = '0;
        end else begin
            if (m_bits < 128) m_tx[7'(127 - m_bits)] = spcm_mosi;
            m_bits++;
        end
    end

    always @(negedge spcm_sck or negedge spcm_cs_n) begin
        mj = m_bits - m_hdr_bits;
        if (mj >= 0 && mj < 128) begin
            mjb = 7'(mj);
            m_miso = m_words[mjb[6:5]][~mjb[4:0]];
        end else m_miso = 1'b0;
    end

    // device model for the CLK_DIV=1 / 32-bit address instance (40 header bits)
    logic [127:0] m2_tx = '0, m2_tx_last = '0;
    int m2_bits = 0, m2_last = 0, m2j = 0;
    logic [31:0] m2_word = '0;
    logic [6:0] m2jb = '0;
    logic m2_miso = 1'b0;

    always @(posedge sck2 or posedge cs2_n) begin
        if (cs2_n) begin
            m2_last = m2_bits; m2_tx_last = m2_tx; m2_bits = 0; m2_tx = '0;
        end else begin
            if (m2_bits < 128) m2_tx[7'(127 - m2_bits)] = mosi2;
            m2_bits++;
        end
    end

    always @(negedge sck2 or negedge cs2_n) begin
        m2j = m2_bits - 40;
        if (m2j >= 0 && m2j < 32) begin
            m2jb = 7'(m2j);
            m2_miso = m2_word[~m2jb[4:0]];
        end else m2_miso = 1'b0;
    end

    spcm_reader u_dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .burst(burst), .fast(fast),
        .dout(dout), .busy(busy), .ack(ack), .spcm_cs_n(spcm_cs_n),
        .spcm_sck(spcm_sck), .spcm_mosi(spcm_mosi), .spcm_miso(m_miso)
    );

    spcm_reader #(.ADDR_BITS(32), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .cs(cs2), .addr(addr2), .burst(1'b0), .fast(1'b0),
        .dout(dout2), .busy(busy2), .ack(ack2), .spcm_cs_n(cs2_n),
        .spcm_sck(sck2), .spcm_mosi(mosi2), .spcm_miso(m2_miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ack_at [4];
    logic [31:0] got [4];
    int n_ack, csn_rise, idle_at;

    // Runs one transaction from cs; cycle 0 is the cycle cs is sampled.
    task automatic do_xfer(input logic f, input logic [21:0] a, input int nwords);
        int cyc;
        n_ack = 0; csn_rise = -1;
        cs = 1'b1; fast = f; addr = a; burst = (nwords > 1);
        @(negedge clk);
        cs = 1'b0; cyc = 1;
        while (busy && cyc < 2000) begin
            if (ack) begin
                if (n_ack < 4) begin ack_at[2'(n_ack)] = cyc; got[2'(n_ack)] = dout; end
                n_ack++;
                burst = (n_ack < nwords);
            end
            if (spcm_cs_n && csn_rise < 0) csn_rise = cyc;
            @(negedge clk); cyc++;
        end
        idle_at = cyc;
        burst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; burst = 1'b0; fast = 1'b0; addr = '0; cs2 = 1'b0; addr2 = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", ack); end
        n_cmp++; if (spcm_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b want 1", spcm_cs_n); end
        n_cmp++; if (spcm_sck !== 1'b0) begin n_err++; $display("FAIL rst_sck: got %b want 0", spcm_sck); end
        n_cmp++; if (spcm_mosi !== 1'b0) begin n_err++; $display("FAIL rst_mosi: got %b want 0", spcm_mosi); end
        n_cmp++; if (busy2 !== 1'b0 || cs2_n !== 1'b1) begin n_err++; $display("FAIL rst_dut2: busy %b cs_n %b want 0 1", busy2, cs2_n); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        m_hdr_bits = 32; m_words[0] = 32'hDEADBEEF;
        do_xfer(1'b0, 22'h01234, 1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_timeout: busy %b at cycle %0d", busy, idle_at); end
        n_cmp++; if (n_ack !== 1) begin n_err++; $display("FAIL rd_ack_count: got %0d want 1", n_ack); end
        n_cmp++; if (ack_at[0] !== 257) begin n_err++; $display("FAIL rd_ack_cycle: got %0d want 257", ack_at[0]); end
        n_cmp++; if (got[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", got[0]); end
        n_cmp++; if (m_tx_last[127:64] !== {8'h03, 24'h0048D0, 32'h0}) begin n_err++; $display("FAIL rd_frame: got %h want 030048d000000000", m_tx_last[127:64]); end
        n_cmp++; if (m_last !== 64) begin n_err++; $display("FAIL rd_sck_edges: got %0d want 64", m_last); end
        n_cmp++; if (idle_at - csn_rise < 4) begin n_err++; $display("FAIL rd_cs_high: got %0d cycles want >=4", idle_at - csn_rise); end
        repeat (10) @(negedge clk);
        n_cmp++; if (dout !== 32'hDEADBEEF || ack !== 1'b0) begin n_err++; $display("FAIL rd_hold: dout %h ack %b want deadbeef 0", dout, ack); end
    endtask

    task automatic test_fast();
        m_hdr_bits = 40; m_words[0] = 32'h5A5AC3C3;
        do_xfer(1'b1, 22'h01234, 1);
        n_cmp++; if (ack_at[0] !== 289 || n_ack !== 1) begin n_err++; $display("FAIL fast_ack_cycle: got %0d (n=%0d) want 289", ack_at[0], n_ack); end
        n_cmp++; if (got[0] !== 32'h5A5AC3C3) begin n_err++; $display("FAIL fast_data: got %h want 5a5ac3c3", got[0]); end
        n_cmp++; if (m_tx_last[127:56] !== {8'h0B, 24'h0048D0, 8'h00, 32'h0}) begin n_err++; $display("FAIL fast_frame: got %h want 0b0048d00000000000", m_tx_last[127:56]); end
        n_cmp++; if (m_last !== 72) begin n_err++; $display("FAIL fast_sck_edges: got %0d want 72", m_last); end
    endtask

    task automatic test_burst();
        m_hdr_bits = 32;
        m_words[0] = 32'h11111111; m_words[1] = 32'h22222222; m_words[2] = 32'h33333333;
        do_xfer(1'b0, 22'h01234, 3);
        n_cmp++; if (n_ack !== 3) begin n_err++; $display("FAIL burst_ack_count: got %0d want 3", n_ack); end
        n_cmp++; if (ack_at[0] !== 257 || ack_at[1] !== 385 || ack_at[2] !== 513) begin n_err++;
            $display("FAIL burst_ack_cycles: got %0d %0d %0d want 257 385 513", ack_at[0], ack_at[1], ack_at[2]); end
        n_cmp++; if (got[0] !== 32'h11111111 || got[1] !== 32'h22222222 || got[2] !== 32'h33333333) begin n_err++;
            $display("FAIL burst_data: got %h %h %h", got[0], got[1], got[2]); end
        n_cmp++; if (m_last !== 128) begin n_err++; $display("FAIL burst_sck_edges: got %0d want 128", m_last); end
        n_cmp++; if (m_tx_last !== {8'h03, 24'h0048D0, 96'h0}) begin n_err++; $display("FAIL burst_frame: got %h", m_tx_last); end
        n_cmp++; if (csn_rise <= ack_at[2]) begin n_err++; $display("FAIL burst_cs_rise: cs_n rose at %0d, last ack %0d", csn_rise, ack_at[2]); end
    endtask

    task automatic test_div1_addr32();
        int cyc, a_at;
        logic [31:0] d;
        m2_word = 32'hA5C30F96; a_at = -1; d = '0;
        cs2 = 1'b1; addr2 = 30'h3FFFFFFF;
        @(negedge clk);
        cs2 = 1'b0; cyc = 1;
        while (busy2 && cyc < 1000) begin
            if (ack2 && a_at < 0) begin a_at = cyc; d = dout2; end
            @(negedge clk); cyc++;
        end
        n_cmp++; if (a_at !== 145) begin n_err++; $display("FAIL div1_ack_cycle: got %0d want 145", a_at); end
        n_cmp++; if (d !== 32'hA5C30F96) begin n_err++; $display("FAIL div1_data: got %h want a5c30f96", d); end
        n_cmp++; if (m2_tx_last[127:56] !== {8'h03, 32'hFFFFFFFC, 32'h0}) begin n_err++; $display("FAIL div1_frame: got %h want 03fffffffc00000000", m2_tx_last[127:56]); end
        n_cmp++; if (m2_last !== 72) begin n_err++; $display("FAIL div1_sck_edges: got %0d want 72", m2_last); end
    endtask

    task automatic test_reset_mid();
        int acks;
        m_hdr_bits = 32; m_words[0] = 32'h0BADF00D;
        cs = 1'b1; fast = 1'b0; addr = 22'h01234;
        @(negedge clk);
        cs = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (spcm_cs_n !== 1'b1 || spcm_sck !== 1'b0 || spcm_mosi !== 1'b0) begin n_err++;
            $display("FAIL abort_pins: cs_n %b sck %b mosi %b want 1 0 0", spcm_cs_n, spcm_sck, spcm_mosi); end
        n_cmp++; if (busy !== 1'b0 || ack !== 1'b0) begin n_err++; $display("FAIL abort_busy_ack: busy %b ack %b want 0 0", busy, ack); end
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL abort_dout: got %h want 0", dout); end
        acks = 0;
        repeat (300) begin @(negedge clk); if (ack) acks++; end
        n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        do_xfer(1'b0, 22'h01234, 1);
        n_cmp++; if (n_ack !== 1 || ack_at[0] !== 257 || got[0] !== 32'h0BADF00D) begin n_err++;
            $display("FAIL abort_recover: n %0d at %0d data %h want 1 257 0badf00d", n_ack, ack_at[0], got[0]); end
    endtask

    task automatic test_back_to_back();
        int cyc, run, gap;
        logic [127:0] frame1;
        m_hdr_bits = 32; m_words[0] = 32'hCAFEF00D;
        n_ack = 0; run = 0; gap = -1; frame1 = '0;
        cs = 1'b1; fast = 1'b0; burst = 1'b0; addr = 22'h00100;
        @(negedge clk);
        addr = 22'h3FFFFF; cyc = 1;
        while (cyc < 1500 && !(n_ack == 2 && !busy)) begin
            if (ack) begin
                if (n_ack < 4) got[2'(n_ack)] = dout;
                n_ack++;
                if (n_ack == 2) cs = 1'b0;
            end
            if (spcm_cs_n) run++;
            else begin
                if (run > 0 && gap < 0) begin gap = run; frame1 = m_tx_last; end
                run = 0;
            end
            @(negedge clk); cyc++;
        end
        cs = 1'b0;
        n_cmp++; if (n_ack !== 2 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_count: got %0d acks busy %b want 2 0", n_ack, busy); end
        n_cmp++; if (got[0] !== 32'hCAFEF00D || got[1] !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_data: got %h %h want cafef00d", got[0], got[1]); end
        n_cmp++; if (gap < 4) begin n_err++; $display("FAIL b2b_cs_gap: got %0d cycles want >=4", gap); end
        n_cmp++; if (frame1[127:64] !== {8'h03, 24'h000400, 32'h0}) begin n_err++; $display("FAIL b2b_frame1: got %h want 0300040000000000", frame1[127:64]); end
        n_cmp++; if (m_tx_last[127:64] !== {8'h03, 24'hFFFFFC, 32'h0}) begin n_err++; $display("FAIL b2b_frame2: got %h want 03fffffc00000000", m_tx_last[127:64]); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_fast();
        test_burst();
        test_div1_addr32();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spcm_reader.md
Name: spcm_reader

Overview:
- Second-generation serial PCM read core. The SPI engine is built in, so no external spi_core is needed.
- Serves word reads from the system bus to a serial PCM/flash device.
- Adds over the first generation:
  - a parametrised SCK divider;
  - a selectable fast-read mode with dummy cycles;
  - a guaranteed chip-select high time;
  - a registered read word that holds its value.
- Sits between the bus adapter and the board SPI pins, for boot and code fetch.

Parameters:
- ADDR_BITS, 24, device address width in bits. Must be ≥ 8 and a multiple of 8.
- CLK_DIV, 2, clk cycles per SCK half-period. Must be ≥ 1.
- DUMMY_BITS, 8, dummy SCK cycles in fast mode. May be 0.
- CS_HIGH_CYCLES, 4, minimum clk cycles spcm_cs_n stays high between transactions. Must be ≥ 1.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- cs  in  1  request; sampled only in IDLE
- addr  in  ADDR_BITS-2  word address, bits [ADDR_BITS-1:2]
- burst  in  1  continue with the next sequential word
- fast  in  1  1 = fast read (opcode 0x0B plus dummy), 0 = read (opcode 0x03); sampled with cs
- dout  out  32  last received word, MSB first
- busy  out  1  transaction in progress
- ack  out  1  one-cycle pulse; dout is new in that cycle
- spcm_cs_n  out  1  device select, active low
- spcm_sck  out  1  SPI clock, mode 0 (idles low)
- spcm_mosi  out  1  serial data to the device
- spcm_miso  in  1  serial data from the device

Behaviour:
- Interface: clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - state IDLE;
  - dout = 0; busy = 0; ack = 0;
  - spcm_cs_n = 1; spcm_sck = 0; spcm_mosi = 0.
- Reset mid-transaction aborts on the next edge, with no ack. The pins return to their reset values immediately, and the CS_HIGH guard is not enforced after reset.
- SPI timing: mode 0, MSB first.
  - mosi is updated at the start of each bit (a falling-edge point).
  - SCK rises after CLK_DIV cycles; miso is sampled in the clk cycle in which SCK rises.
  - SCK falls after a further CLK_DIV cycles.
  - One bit therefore takes 2*CLK_DIV clk cycles.
- On-wire frame: opcode[7:0], then {addr, 2'b00} (ADDR_BITS bits), then DUMMY_BITS bits of 0 (fast mode only), then 32-bit data words.
- FSM states and transitions:
  - IDLE: when cs=1, latch addr and fast, go to CMD. spcm_cs_n goes low and busy goes high in the next cycle.
  - CMD: 8 bits, then ADDR.
  - ADDR: ADDR_BITS bits, then DUMMY if fast=1 and DUMMY_BITS>0, otherwise DATA.
  - DUMMY: DUMMY_BITS bits with mosi=0, then DATA.
  - DATA: shift in 32 bits.
    - After the last sample edge, dout is loaded and ack=1 for one cycle.
    - burst is sampled in the ack cycle: 1 → continue DATA with no gap in SCK; 0 → go to CLOSE.
  - CLOSE: finish the current SCK low half-period, then spcm_cs_n=1, then hold for CS_HIGH_CYCLES, then IDLE.
- busy is high from the cycle after cs is accepted until the last CLOSE cycle inclusive.
- Latency (counted from the cycle cs is sampled, as cycle 0): first ack at cycle 1 + (8 + ADDR_BITS + D + 32)·2·CLK_DIV.
  - D = DUMMY_BITS if fast, else 0.
  - Defaults: 257 in read mode, 289 in fast mode.
- Burst words ack every 64·CLK_DIV cycles (128 at defaults).
- Address wrap is left to the device. The core sends no new address in a burst.
- cs and addr changes during busy are ignored.
- If cs is still high on the first IDLE cycle after CLOSE, a new transaction starts.
- dout holds its value between acks. ack is never asserted outside DATA.

Decomposition:
- Shared package constants:
  - SPCM_OP_READ = 8'h03 and SPCM_OP_FAST_READ = 8'h0B;
  - FSM state encoding S_IDLE/S_CMD/S_ADDR/S_DUMMY/S_DATA/S_CLOSE.
- Sub-module spcm_shifter: SCK divider, bit counter, mosi/miso shift registers, and bit-done/sample strobes, controlled by the FSM.

Test Plan:
1. Read, defaults: addr = 0x01234 word (byte address 0x0048D0); model returns 0xDEADBEEF → mosi carries 0x03, 0x00, 0x48, 0xD0; ack at cycle 257; dout = 0xDEADBEEF; spcm_cs_n high ≥ 4 cycles after.
2. Fast read with DUMMY_BITS = 8: same address → 0x0B opcode plus 8 zero bits seen by the model; ack at cycle 289; data correct.
3. Burst of 3 words (burst held until the 3rd ack): model data 0x11111111, 0x22222222, 0x33333333 → acks at 257, 385, 513; no SCK gap and no re-command; cs_n rises after the 3rd word.
4. CLK_DIV = 1, ADDR_BITS = 32: addr = 0x3FFFFFFF → 0xFFFFFFFC sent; ack at cycle 1 + 72·2 = 145.
5. rst asserted at cycle 100 of a read → next cycle spcm_cs_n = 1, sck = 0, busy = 0, no ack; a new cs after reset completes normally.
6. cs held high continuously → back-to-back transactions, each separated by ≥ CS_HIGH_CYCLES of cs_n high; addr changed during busy is not used.
